// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational IF-stage lookup, ID-stage training, and saturating hit/mispredict statistics.
module branch_target_buffer #(
   parameter int         ADDR_W   = 32,
   parameter int         ENTRIES  = 16,
   parameter logic [1:0] CNT_INIT = 2'b01,
   parameter int         STAT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lookupEn,
   input  logic [ADDR_W-1:0] lookupPc,
   output logic              hit,
   output logic              predTaken,
   output logic [ADDR_W-1:0] predNextPc,
   input  logic              updateEn,
   input  logic [ADDR_W-1:0] updatePc,
   input  logic              updateTaken,
   input  logic [ADDR_W-1:0] updateTarget,
   input  logic              updatePredTaken,
   input  logic              invalidate,
   output logic              mispredict,
   output logic [STAT_W-1:0] lookupCount,
   output logic [STAT_W-1:0] hitCount,
   output logic [STAT_W-1:0] mispredictCount
);

   localparam int INDEX_W = $clog2(ENTRIES);
   localparam int TAG_W   = ADDR_W - INDEX_W - 2;

   logic              validQ  [ENTRIES];
   logic [TAG_W-1:0]  tagQ    [ENTRIES];
   logic [ADDR_W-3:0] targetQ [ENTRIES];
   logic [1:0]        ctrQ    [ENTRIES];

   logic [INDEX_W-1:0] lookupIdx;
   logic [TAG_W-1:0]   lookupTag;
   logic [INDEX_W-1:0] updIdx;
   logic [TAG_W-1:0]   updTag;
   logic               updHit;
   logic               updWrite;
   logic               unusedBits;

   assign lookupIdx = lookupPc[INDEX_W+1:2];
   assign lookupTag = lookupPc[ADDR_W-1:INDEX_W+2];
   assign updIdx    = updatePc[INDEX_W+1:2];
   assign updTag    = updatePc[ADDR_W-1:INDEX_W+2];

   // Byte offsets of the update PC and target carry no information for word-aligned code.
   assign unusedBits = ^{updatePc[1:0], updateTarget[1:0]};

   assign hit        = validQ[lookupIdx] && (tagQ[lookupIdx] == lookupTag);
   assign predTaken  = hit && ctrQ[lookupIdx][1];
   assign predNextPc = predTaken ? {targetQ[lookupIdx], 2'b00} : lookupPc + ADDR_W'(4);

   assign updHit     = validQ[updIdx] && (tagQ[updIdx] == updTag);
   assign mispredict = updateEn && (updatePredTaken != updateTaken);
   assign updWrite   = !rst && !invalidate && updateEn && updateTaken;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            validQ[i] <= 1'b0;
            ctrQ[i]   <= CNT_INIT;
         end
      end else if (invalidate) begin
         for (int i = 0; i < ENTRIES; i++) begin
            validQ[i] <= 1'b0;
         end
      end else if (updateEn) begin
         if (updHit) begin
            if (updateTaken) begin
               if (ctrQ[updIdx] != 2'b11) ctrQ[updIdx] <= ctrQ[updIdx] + 2'b01;
            end else begin
               if (ctrQ[updIdx] != 2'b00) ctrQ[updIdx] <= ctrQ[updIdx] - 2'b01;
            end
         end else if (updateTaken) begin
            validQ[updIdx] <= 1'b1;
            ctrQ[updIdx]   <= 2'b10;
         end
      end
   end

   // Tag and target are don't-care under reset, so they live outside the reset domain.
   // On an update hit the tag rewrite is a no-op, which keeps the enable simple.
   always_ff @(posedge clk) begin
      if (updWrite) begin
         tagQ[updIdx]    <= updTag;
         targetQ[updIdx] <= updateTarget[ADDR_W-1:2];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lookupCount     <= '0;
         hitCount        <= '0;
         mispredictCount <= '0;
      end else begin
         if (lookupEn && (lookupCount != '1))
            lookupCount <= lookupCount + STAT_W'(1);
         if (lookupEn && hit && (hitCount != '1))
            hitCount <= hitCount + STAT_W'(1);
         if (mispredict && (mispredictCount != '1))
            mispredictCount <= mispredictCount + STAT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios plus random traffic against an
// entry-level reference model; a second instance with narrow statistics checks saturation.
module tb_branch_target_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        lookupEn;
   logic [31:0] lookupPc;
   logic        updateEn;
   logic [31:0] updatePc;
   logic        updateTaken;
   logic [31:0] updateTarget;
   logic        updatePredTaken;
   logic        invalidate;

   logic        hit, predTaken, mispredict;
   logic [31:0] predNextPc;
   logic [15:0] lookupCount, hitCount, mispredictCount;

   logic        hitS, predTakenS, mispredictS;
   logic [31:0] predNextPcS;
   logic [3:0]  lookupCountS, hitCountS, mispredictCountS;

   int numChecks = 0;
   int numPass   = 0;

   branch_target_buffer dut (
      .clk(clk), .rst(rst), .lookupEn(lookupEn), .lookupPc(lookupPc),
      .hit(hit), .predTaken(predTaken), .predNextPc(predNextPc),
      .updateEn(updateEn), .updatePc(updatePc), .updateTaken(updateTaken),
      .updateTarget(updateTarget), .updatePredTaken(updatePredTaken),
      .invalidate(invalidate), .mispredict(mispredict),
      .lookupCount(lookupCount), .hitCount(hitCount), .mispredictCount(mispredictCount)
   );

   branch_target_buffer #(.STAT_W(4)) dutSmall (
      .clk(clk), .rst(rst), .lookupEn(lookupEn), .lookupPc(lookupPc),
      .hit(hitS), .predTaken(predTakenS), .predNextPc(predNextPcS),
      .updateEn(updateEn), .updatePc(updatePc), .updateTaken(updateTaken),
      .updateTarget(updateTarget), .updatePredTaken(updatePredTaken),
      .invalidate(invalidate), .mispredict(mispredictS),
      .lookupCount(lookupCountS), .hitCount(hitCountS), .mispredictCount(mispredictCountS)
   );

   always #5 clk = ~clk;

   // Reference model: each entry remembers the full word address it was trained on.
   bit          mValid [16];
   logic [29:0] mWord  [16];
   logic [29:0] mTgt   [16];
   int          mCtr   [16];
   int          totLookups, totHits, totMisp;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      numChecks++;
      if (got === exp) numPass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic int satMin(input int v, input int maxV);
      return (v > maxV) ? maxV : v;
   endfunction

   function automatic bit modelHit(input logic [31:0] pc);
      int idx = int'(pc[31:2]) % 16;
      return mValid[idx] && (mWord[idx] == pc[31:2]);
   endfunction

   function automatic logic [31:0] modelNext(input logic [31:0] pc);
      int idx = int'(pc[31:2]) % 16;
      if (modelHit(pc) && mCtr[idx] >= 2) return {mTgt[idx], 2'b00};
      return pc + 32'd4;
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 16; i++) begin
         mValid[i] = 0;
         mCtr[i]   = 1;
      end
      totLookups = 0;
      totHits    = 0;
      totMisp    = 0;
   endfunction

   function automatic void modelEdge();
      int  idx;
      bit  lookHit;
      bit  misp;
      if (rst) begin
         modelReset();
         return;
      end
      lookHit = modelHit(lookupPc);
      misp    = updateEn && (updatePredTaken != updateTaken);
      if (lookupEn) totLookups++;
      if (lookupEn && lookHit) totHits++;
      if (misp) totMisp++;
      if (invalidate) begin
         for (int i = 0; i < 16; i++) mValid[i] = 0;
      end else if (updateEn) begin
         idx = int'(updatePc[31:2]) % 16;
         if (modelHit(updatePc)) begin
            mCtr[idx] = updateTaken ? satMin(mCtr[idx] + 1, 3)
                                    : ((mCtr[idx] > 0) ? mCtr[idx] - 1 : 0);
            if (updateTaken) mTgt[idx] = updateTarget[31:2];
         end else if (updateTaken) begin
            mValid[idx] = 1;
            mWord[idx]  = updatePc[31:2];
            mTgt[idx]   = updateTarget[31:2];
            mCtr[idx]   = 2;
         end
      end
   endfunction

   task automatic compareAll();
      bit h;
      h = modelHit(lookupPc);
      checkVal("hit", {31'd0, hit}, {31'd0, h});
      checkVal("predTaken", {31'd0, predTaken},
               {31'd0, h && mCtr[int'(lookupPc[31:2]) % 16] >= 2});
      checkVal("predNextPc", predNextPc, modelNext(lookupPc));
      checkVal("mispredict", {31'd0, mispredict},
               {31'd0, updateEn && (updatePredTaken != updateTaken)});
      checkVal("lookupCount", {16'd0, lookupCount}, satMin(totLookups, 65535));
      checkVal("hitCount", {16'd0, hitCount}, satMin(totHits, 65535));
      checkVal("mispredictCount", {16'd0, mispredictCount}, satMin(totMisp, 65535));
      checkVal("lookupCountS", {28'd0, lookupCountS}, satMin(totLookups, 15));
      checkVal("hitCountS", {28'd0, hitCountS}, satMin(totHits, 15));
      checkVal("mispredictCountS", {28'd0, mispredictCountS}, satMin(totMisp, 15));
   endtask

   task automatic step();
      #2;
      compareAll();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic setIdle();
      rst = 0; lookupEn = 0; lookupPc = 32'h40; updateEn = 0; updatePc = 0;
      updateTaken = 0; updateTarget = 0; updatePredTaken = 0; invalidate = 0;
   endtask

   task automatic doUpdate(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                           input bit pt);
      setIdle();
      updateEn = 1; updatePc = pc; updateTaken = tk; updateTarget = tgt; updatePredTaken = pt;
      step();
      setIdle();
   endtask

   task automatic doLookup(input logic [31:0] pc);
      setIdle();
      lookupEn = 1; lookupPc = pc;
      step();
      setIdle();
   endtask

   task automatic peek(input logic [31:0] pc, input string tag, input bit expHit,
                       input logic [31:0] expNext);
      setIdle();
      lookupPc = pc;
      #1;
      checkVal({tag, "Hit"}, {31'd0, hit}, {31'd0, expHit});
      checkVal({tag, "Next"}, predNextPc, expNext);
   endtask

   function automatic logic [31:0] randPc();
      logic [31:0] pc;
      pc = ($urandom % 3) * 32'h40 + (($urandom % 16) << 2) + ($urandom % 4);
      if ($urandom % 8 == 0) pc = pc | 32'hFFFF_FFC0;
      return pc;
   endfunction

   initial begin
      setIdle();
      rst = 1;
      @(posedge clk);
      modelReset();
      #1;
      setIdle();

      // Reset state
      peek(32'h40, "t1", 0, 32'h44);
      checkVal("t1LookupCount", {16'd0, lookupCount}, 0);
      checkVal("t1MispCount", {16'd0, mispredictCount}, 0);
      step();
      peek(32'hFFFF_FFFC, "wrap", 0, 32'h0);

      // First taken update allocates
      setIdle();
      updateEn = 1; updatePc = 32'h40; updateTaken = 1; updateTarget = 32'h100;
      #1;
      checkVal("t2Misp", {31'd0, mispredict}, 1);
      step();
      peek(32'h40, "t2", 1, 32'h100);
      checkVal("t2MispCount", {16'd0, mispredictCount}, 1);

      // Counter walks down and saturates, then up and saturates
      for (int i = 0; i < 3; i++) doUpdate(32'h40, 0, 32'h0, 1);
      peek(32'h40, "t3Down", 1, 32'h44);
      doUpdate(32'h40, 1, 32'h100, 0);
      peek(32'h40, "t3Weak", 1, 32'h44);
      for (int i = 0; i < 3; i++) doUpdate(32'h40, 1, 32'h100, 0);
      peek(32'h40, "t3Up", 1, 32'h100);
      doUpdate(32'h40, 0, 32'h0, 1);
      peek(32'h40, "t3Sat", 1, 32'h100);
      doUpdate(32'h40, 1, 32'h100, 1);

      // Aliasing index, different tag
      doUpdate(32'h80, 1, 32'h200, 0);
      peek(32'h40, "t4Old", 0, 32'h44);
      peek(32'h80, "t4New", 1, 32'h200);
      doUpdate(32'hC0, 0, 32'h0, 1);
      peek(32'h80, "t4Keep", 1, 32'h200);

      // Same-cycle lookup sees pre-update state
      setIdle();
      lookupEn = 1; lookupPc = 32'h80;
      updateEn = 1; updatePc = 32'h80; updateTaken = 1; updateTarget = 32'h300; updatePredTaken = 1;
      #1;
      checkVal("t5Before", predNextPc, 32'h200);
      step();
      peek(32'h80, "t5After", 1, 32'h300);

      // Invalidate wins over a same-cycle allocation
      setIdle();
      invalidate = 1; updateEn = 1; updatePc = 32'h144; updateTaken = 1; updateTarget = 32'h500;
      step();
      peek(32'h80, "t5InvA", 0, 32'h84);
      peek(32'h144, "t5InvB", 0, 32'h148);
      checkVal("t5InvMisp", {16'd0, mispredictCount}, 32'(satMin(totMisp, 65535)));

      // Reset mid-training discards the same-cycle update
      doUpdate(32'h40, 1, 32'h100, 0);
      setIdle();
      rst = 1; updateEn = 1; updatePc = 32'h40; updateTaken = 1; updateTarget = 32'h100;
      step();
      peek(32'h40, "t5Rst", 0, 32'h44);
      checkVal("t5RstLookup", {16'd0, lookupCount}, 0);
      checkVal("t5RstMisp", {16'd0, mispredictCount}, 0);

      // Statistics: 5 lookups with 3 hits, then saturation of the narrow instance
      doUpdate(32'h40, 1, 32'h100, 1);
      for (int i = 0; i < 5; i++) doLookup((i < 3) ? 32'h40 : 32'h80);
      checkVal("t6Look5", {28'd0, lookupCountS}, 5);
      checkVal("t6Hit3", {28'd0, hitCountS}, 3);
      for (int i = 0; i < 20; i++) doLookup(32'h40);
      checkVal("t6LookSat", {28'd0, lookupCountS}, 15);
      checkVal("t6HitSat", {28'd0, hitCountS}, 15);
      checkVal("t6LookWide", {16'd0, lookupCount}, 25);
      checkVal("t6HitWide", {16'd0, hitCount}, 23);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         lookupEn        = ($urandom % 4) != 0;
         lookupPc        = randPc();
         updateEn        = $urandom % 2;
         updatePc        = randPc();
         updateTaken     = $urandom % 2;
         updateTarget    = $urandom;
         updatePredTaken = $urandom % 2;
         invalidate      = ($urandom % 64) == 0;
         rst             = ($urandom % 300) == 0;
         step();
      end
      setIdle();
      step();

      $display("%0d/%0d checks passed", numPass, numChecks);
      $finish;
   end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core.
- Sits in IF beside the PC register and gives a next-PC prediction in the same cycle.
- ID-stage branch/jump resolution trains it through the update port.
- Replaces the fixed "assume not-taken, flush on taken" policy with configurable-depth dynamic prediction and built-in hit/mispredict statistics.

Parameters:
ADDR_W, 32, PC/target width in bits
ENTRIES, 16, number of BTB entries; power of two, >= 2; INDEX_W = log2(ENTRIES)
CNT_INIT, 2'b01, counter value written at reset (weakly not-taken)
STAT_W, 16, width of each statistics counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
lookupEn  input  1  IF lookup valid; qualifies statistics only
lookupPc  input  ADDR_W  PC being fetched
hit  output  1  valid entry with matching tag for lookupPc
predTaken  output  1  hit and counter MSB set
predNextPc  output  ADDR_W  predicted next PC
updateEn  input  1  resolved control-flow instruction in ID this cycle
updatePc  input  ADDR_W  PC of the resolved instruction
updateTaken  input  1  actual outcome
updateTarget  input  ADDR_W  actual target; word aligned
updatePredTaken  input  1  prediction that was made for this instruction
invalidate  input  1  clear all valid bits (context switch / self-modifying code)
mispredict  output  1  updateEn and (updatePredTaken != updateTaken); combinational
lookupCount  output  STAT_W  qualified lookups
hitCount  output  STAT_W  qualified lookups that hit
mispredictCount  output  STAT_W  mispredicted updates

Behaviour:
- Address split:
  - index = pc[INDEX_W+1:2]
  - tag = pc[ADDR_W-1:INDEX_W+2]
  - pc[1:0] ignored everywhere
- Entry contents: valid, tag, target[ADDR_W-1:2], ctr[1:0].
- Lookup is combinational, zero latency:
  - hit = valid[idx] & tag match
  - predTaken = hit & ctr[idx][1]
  - predNextPc = predTaken ? {target,2'b00} : lookupPc+4
  - lookupPc+4 wraps modulo 2^ADDR_W.
- Update, on the clock edge when updateEn=1 and invalidate=0:
  - Update hit (valid and tag match):
    - ctr saturating +1 if updateTaken, else -1; 11 stays 11 on taken, 00 stays 00 on not-taken.
    - Target overwritten only when updateTaken.
  - Update miss and updateTaken:
    - Allocate or replace the entry: valid=1, tag, target, ctr=2'b10.
  - Update miss and not taken: no state change.
- Read/write ordering:
  - A lookup in the same cycle as an update to the same index sees the pre-update state; no bypass.
  - The new state is visible the cycle after the edge.
- invalidate:
  - Clears every valid bit at the edge.
  - Takes priority over a same-cycle updateEn, which is dropped. Its mispredict is still counted.
  - Tags, targets, counters and statistics are unchanged.
- Statistics, all saturating at all-ones (no wrap):
  - lookupCount += lookupEn
  - hitCount += lookupEn & hit
  - mispredictCount += mispredict
- rst:
  - Highest priority.
  - All valid=0, all ctr=CNT_INIT, all statistics=0.
  - Tags and targets are don't-care.
  - After reset: hit=0, predTaken=0, predNextPc=lookupPc+4, mispredict follows its inputs.
- Reset asserted mid-operation discards any same-cycle update or invalidate.
- With no enables asserted, state holds.
- Storage is flop-based; no memory macros.

Test Plan:
1. Reset; lookupPc=0x40 -> hit=0, predTaken=0, predNextPc=0x44; all counters 0.
2. updateEn, updatePc=0x40, taken, updateTarget=0x100, updatePredTaken=0 -> mispredict=1 that cycle. Next cycle lookup 0x40 gives hit=1, predTaken=1, predNextPc=0x100, mispredictCount=1.
3. From test 2, apply three not-taken updates to 0x40 -> ctr 10→01→00→00; lookup gives hit=1, predTaken=0, predNextPc=0x44. Then four taken updates -> ctr saturates at 11, predNextPc=0x100.
4. ENTRIES=16: train 0x40 taken to 0x100, then update 0x80 taken to 0x200 (same index, different tag) -> lookup 0x40 gives hit=0, predNextPc=0x44; lookup 0x80 gives predNextPc=0x200. A not-taken update to miss PC 0xC0 leaves 0x80 intact.
5. Same-cycle lookup of 0x40 with a taken update to 0x40 -> lookup shows the old value, new value next cycle. invalidate with updateEn in the same cycle -> all hit=0 afterwards; rst pulsed mid-training -> identical state to test 1.
6. STAT_W=4: 20 cycles lookupEn=1 on a trained PC -> lookupCount=15, hitCount=15 (saturated). 5 lookups with 3 hits from reset -> lookupCount=5, hitCount=3.
